// File: rtl/text_line_pkg.sv
// Shared constants and glyph primitives for the text line overlay.
// insideBox is the rectangle test; letterBit is the 8x8 glyph ROM scaled by 4.
package text_line_pkg;

  localparam int LETTER_WIDTH = 32;
  localparam int LETTER_HEIGHT = 32;
  localparam int GLYPH_SHIFT = 2;
  localparam logic [7:0] COLOR_TRANSPARENT = 8'hFF;
  localparam logic [7:0] COLOR_DEFAULT = 8'h1F;
  localparam logic [3:0] LETTER_BLANK = 4'hF;
  localparam int LETTER_CODE_W = 4;
  localparam int MAX_TEXT_CHARS = 16;

  // One 64-bit word per code: row 0 in the top byte, column 0 in the byte's MSB.
  localparam logic [63:0] GLYPH_ROM [16] = '{
    64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00, 64'h7E060C1830303000,
    64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
    64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607C60607E00, 64'h0000000000000000
  };

  function automatic logic insideBox(input logic [10:0] px, input logic [10:0] py,
                                     input logic [10:0] ox, input logic [10:0] oy);
    return (px >= ox) && (px < ox + 11'(LETTER_WIDTH)) &&
           (py >= oy) && (py < oy + 11'(LETTER_HEIGHT));
  endfunction

  function automatic logic letterBit(input logic [3:0] code, input logic [2:0] row,
                                     input logic [2:0] col);
    logic [63:0] glyph;
    glyph = GLYPH_ROM[code];
    return glyph[~{row, col}];
  endfunction

endpackage

// File: rtl/text_line_slot_decoder.sv
// Combinational line decoder: which slot the pixel falls in, the rotated buffer
// index for that slot, and the pixel offset from the slot origin.
module text_slot_decoder
  import text_line_pkg::*;
#(
  parameter int NUM_CHARS  = 8,
  parameter int TOP_LEFT_X = 200,
  parameter int TOP_LEFT_Y = 5,
  parameter int CHAR_PITCH = 50
) (
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [3:0]  startIdx,
  output logic        hit,
  output logic [3:0]  bufIdx,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY
);

  localparam logic [10:0] ORIGIN_Y = 11'(TOP_LEFT_Y);
  localparam logic [4:0] NUM_CHARS_W = 5'(NUM_CHARS);

  logic [3:0]  slotIdx;
  logic [10:0] originX;
  logic [4:0]  rotIdx;

  always_comb begin
    hit = 1'b0;
    slotIdx = '0;
    originX = 11'(TOP_LEFT_X);
    // Slots never overlap (pitch >= width), so at most one box matches.
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (insideBox(pixelX, pixelY, 11'(TOP_LEFT_X + i * CHAR_PITCH), ORIGIN_Y)) begin
        hit = 1'b1;
        slotIdx = 4'(i);
        originX = 11'(TOP_LEFT_X + i * CHAR_PITCH);
      end
    end
    // Both operands are below NUM_CHARS, so one conditional subtract is the modulo.
    rotIdx = {1'b0, slotIdx} + {1'b0, startIdx};
    bufIdx = (rotIdx >= NUM_CHARS_W) ? 4'(rotIdx - NUM_CHARS_W) : rotIdx[3:0];
    offsetX = pixelX - originX;
    offsetY = pixelY - ORIGIN_Y;
  end

endmodule

// File: rtl/text_line.sv
// N-slot text line overlay with marquee rotation and a 2-cycle pixel pipeline.
// Optional per-slot blinking is built when TEXT_BLINK_EN is defined.
module text_line
  import text_line_pkg::*;
#(
  parameter int NUM_CHARS     = 8,
  parameter int TOP_LEFT_X    = 200,
  parameter int TOP_LEFT_Y    = 5,
  parameter int CHAR_PITCH    = 50,
  parameter int SCROLL_FRAMES = 30,
  parameter int BLINK_FRAMES  = 15
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        wrEn,
  input  logic [3:0]  wrIndex,
  input  logic [3:0]  wrLetter,
  input  logic        wrBlink,
  input  logic        scrollEn,
  output logic        drawText,
  output logic [7:0]  RGBText
);

  localparam int FRAME_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SCROLL_FRAMES - 1);
  localparam logic [4:0] NUM_CHARS_W = 5'(NUM_CHARS);
  localparam logic [3:0] LAST_SLOT = 4'(NUM_CHARS - 1);

  logic [LETTER_CODE_W-1:0] letterBuf [MAX_TEXT_CHARS];
  logic [FRAME_W-1:0] frameCnt;
  logic [3:0]  startIdx;
  logic        wrOk;
  logic        decHit;
  logic [3:0]  decIdx;
  logic [10:0] decOffX, decOffY;
  logic        blinkSuppress;
  logic        s1Valid, s1Hit, s1Suppress;
  logic [3:0]  s1Letter;
  logic [10:0] s1OffX, s1OffY;
  logic        glyphOn;
  logic        unusedOffsetBits;

  assign wrOk = wrEn && ({1'b0, wrIndex} < NUM_CHARS_W);

  // Entries at or above NUM_CHARS are never written and stay blank.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < MAX_TEXT_CHARS; i++) letterBuf[i] <= LETTER_BLANK;
    end else if (wrOk) begin
      letterBuf[wrIndex] <= wrLetter;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frameCnt <= '0;
      startIdx <= '0;
    end else if (startOfFrame && scrollEn) begin
      if (frameCnt == FRAME_LAST) begin
        frameCnt <= '0;
        startIdx <= (startIdx == LAST_SLOT) ? 4'd0 : startIdx + 4'd1;
      end else begin
        frameCnt <= frameCnt + 1'b1;
      end
    end
  end

`ifdef TEXT_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic               blinkBuf [MAX_TEXT_CHARS];
  logic [BLINK_W-1:0] blinkCnt;
  logic               blinkOn;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < MAX_TEXT_CHARS; i++) blinkBuf[i] <= 1'b0;
    end else if (wrOk) begin
      blinkBuf[wrIndex] <= wrBlink;
    end
  end

  // Blink phase runs on every frame, independent of scrollEn.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blinkCnt <= '0;
      blinkOn <= 1'b1;
    end else if (startOfFrame) begin
      if (blinkCnt == BLINK_LAST) begin
        blinkCnt <= '0;
        blinkOn <= ~blinkOn;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end
    end
  end

  assign blinkSuppress = blinkBuf[decIdx] & ~blinkOn;
`else
  localparam int unusedBlinkFrames = BLINK_FRAMES;
  logic unusedBlink;
  assign unusedBlink = wrBlink;
  assign blinkSuppress = 1'b0;
`endif

  text_slot_decoder #(
    .NUM_CHARS (NUM_CHARS),
    .TOP_LEFT_X(TOP_LEFT_X),
    .TOP_LEFT_Y(TOP_LEFT_Y),
    .CHAR_PITCH(CHAR_PITCH)
  ) u_decoder (
    .pixelX  (pixelX),
    .pixelY  (pixelY),
    .startIdx(startIdx),
    .hit     (decHit),
    .bufIdx  (decIdx),
    .offsetX (decOffX),
    .offsetY (decOffY)
  );

  // Stage 1: buffer and startIdx are sampled here, so updates at edge k
  // reach the pixel presented during cycle k.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1Valid <= 1'b0;
      s1Hit <= 1'b0;
      s1Suppress <= 1'b0;
      s1Letter <= LETTER_BLANK;
      s1OffX <= '0;
      s1OffY <= '0;
    end else begin
      s1Valid <= 1'b1;
      s1Hit <= decHit;
      s1Suppress <= decHit & blinkSuppress;
      s1Letter <= decHit ? letterBuf[decIdx] : LETTER_BLANK;
      s1OffX <= decOffX;
      s1OffY <= decOffY;
    end
  end

  assign glyphOn = letterBit(s1Letter, s1OffY[GLYPH_SHIFT +: 3], s1OffX[GLYPH_SHIFT +: 3]);
  assign unusedOffsetBits = ^{s1OffX, s1OffY};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawText <= 1'b0;
      RGBText <= COLOR_TRANSPARENT;
    end else if (s1Valid && s1Hit && (s1Letter != LETTER_BLANK) && !s1Suppress && glyphOn) begin
      drawText <= 1'b1;
      RGBText <= COLOR_DEFAULT;
    end else begin
      drawText <= 1'b0;
      RGBText <= COLOR_TRANSPARENT;
    end
  end

endmodule

// File: tb/tb_text_line.sv
// Bench for text_line: a behavioural line model predicts every output cycle,
// plus literal probes on known glyph pixels, scroll positions, reset and blink.
module tb_text_line;
  import text_line_pkg::*;

  localparam int NC = 4;
  localparam int X0 = 200;
  localparam int Y0 = 5;
  localparam int PITCH = 50;
  localparam int SF = 2;
  localparam int BF = 3;
  localparam logic [8:0] MISS = {1'b0, COLOR_TRANSPARENT};
  localparam logic [8:0] LIT = {1'b1, COLOR_DEFAULT};

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        startOfFrame = 1'b0;
  logic        wrEn = 1'b0;
  logic [3:0]  wrIndex = '0;
  logic [3:0]  wrLetter = '0;
  logic        wrBlink = 1'b0;
  logic        scrollEn = 1'b0;
  logic        drawText;
  logic [7:0]  RGBText;

  text_line #(
    .NUM_CHARS(NC), .TOP_LEFT_X(X0), .TOP_LEFT_Y(Y0), .CHAR_PITCH(PITCH),
    .SCROLL_FRAMES(SF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .wrEn(wrEn), .wrIndex(wrIndex), .wrLetter(wrLetter),
    .wrBlink(wrBlink), .scrollEn(scrollEn), .drawText(drawText), .RGBText(RGBText)
  );

  // clock/reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];

  // behavioural line state
  int mBuf [NC];
  bit mBlink [NC];
  int mStart, mFrame, mBlinkCnt;
  bit mBlinkOn;

  function automatic logic [8:0] modelPixel(int px, int py);
    logic [8:0] res;
    res = MISS;
    for (int i = 0; i < NC; i++) begin
      int ox;
      ox = X0 + i * PITCH;
      if (px >= ox && px < ox + LETTER_WIDTH && py >= Y0 && py < Y0 + LETTER_HEIGHT) begin
        int b, row, col, code;
        logic [63:0] g;
        logic [7:0] rowBits;
        bit lit;
        b = (i + mStart) % NC;
        code = mBuf[b];
        row = (py - Y0) / (LETTER_HEIGHT / 8);
        col = (px - ox) / (LETTER_WIDTH / 8);
        g = GLYPH_ROM[code];
        rowBits = 8'((g >> (56 - 8 * row)) & 64'hFF);
        lit = (code != 15) && rowBits[7 - col];
`ifdef TEXT_BLINK_EN
        if (mBlink[b] && !mBlinkOn) lit = 1'b0;
`endif
        if (lit) res = LIT;
      end
    end
    return res;
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got draw=%0b rgb=%02h, want draw=%0b rgb=%02h at %0t",
               name, act[8], act[7:0], exp[8], exp[7:0], $time);
    end
  endtask

  // model update: expected pixel from pre-edge state, then apply writes/frames
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NC; i++) begin
        mBuf[i] = 15;
        mBlink[i] = 1'b0;
      end
      mStart = 0;
      mFrame = 0;
      mBlinkCnt = 0;
      mBlinkOn = 1'b1;
      exp_q.delete();
      exp_q.push_back(MISS);
    end else begin
      exp_q.push_back(modelPixel(int'(pixelX), int'(pixelY)));
      if (wrEn && int'(wrIndex) < NC) begin
        mBuf[wrIndex] = int'(wrLetter);
        mBlink[wrIndex] = wrBlink;
      end
      if (startOfFrame) begin
        if (scrollEn) begin
          mFrame++;
          if (mFrame == SF) begin
            mFrame = 0;
            mStart = (mStart + 1) % NC;
          end
        end
        mBlinkCnt++;
        if (mBlinkCnt == BF) begin
          mBlinkCnt = 0;
          mBlinkOn = !mBlinkOn;
        end
      end
    end
  end

  // scoreboard: outputs after edge m belong to the pixel sampled at edge m-1
  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_q.size() >= 2) e = exp_q.pop_front();
    else e = MISS;
    check("pipe", {drawText, RGBText}, e);
  end

  // driver tasks
  task automatic step(int x, int y, bit sof, bit we, int wi, int wl, bit wb);
    @(negedge clk);
    pixelX = 11'(x);
    pixelY = 11'(y);
    startOfFrame = sof;
    wrEn = we;
    wrIndex = 4'(wi);
    wrLetter = 4'(wl);
    wrBlink = wb;
  endtask

  task automatic write(int idx, int letter, bit blink);
    step(0, 0, 1'b0, 1'b1, idx, letter, blink);
  endtask

  task automatic pulse();
    step(0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic probe(string name, int x, int y, bit expDraw);
    step(x, y, 1'b0, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check(name, {drawText, RGBText}, expDraw ? LIT : MISS);
  endtask

  task automatic doReset();
    @(negedge clk);
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", {drawText, RGBText}, MISS);
    resetN = 1'b1;
  endtask

  task automatic scanLine();
    for (int y = 3; y < 39; y++)
      for (int x = 195; x < 390; x++)
        step(x, y, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    doReset();
    scanLine();

    write(0, 0, 1'b0);
    write(1, 1, 1'b0);
    // latency: miss pixel held, then a lit pixel of '0' (row 0, col 2)
    step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    step(208, 5, 1'b0, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #1;
    check("lat_1cyc", {drawText, RGBText}, MISS);
    @(posedge clk); #1;
    check("lat_2cyc", {drawText, RGBText}, LIT);
    probe("slot0_col0", 200, 5, 1'b0);
    probe("gap_right_edge", X0 + LETTER_WIDTH, 5, 1'b0);
    probe("slot1_letter1", 262, 5, 1'b1);

    write(9, 5, 1'b0);
    probe("idx9_ignored", 208, 5, 1'b1);
    write(2, 2, 1'b0);
    write(3, 3, 1'b0);
    scanLine();

    // marquee: 6 enabled pulses put letter 3 in slot 0
    scrollEn = 1'b1;
    repeat (6) pulse();
    probe("scroll6_r4c5", 220, 21, 1'b1);
    probe("scroll6_r3c2", 208, 17, 1'b0);
    scrollEn = 1'b0;
    repeat (3) pulse();
    probe("freeze_r4c5", 220, 21, 1'b1);
    probe("freeze_r3c2", 208, 17, 1'b0);
    scrollEn = 1'b1;
    repeat (3) pulse();
    probe("scroll_wrap", 208, 17, 1'b1);
    scrollEn = 1'b0;

    // asynchronous reset while a lit pixel is on the output
    probe("pre_reset", 208, 5, 1'b1);
    #1;
    resetN = 1'b0;
    #1;
    check("async_reset", {drawText, RGBText}, MISS);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    probe("post_reset_blank", 208, 5, 1'b0);
    scanLine();

`ifdef TEXT_BLINK_EN
    write(0, 0, 1'b0);
    write(1, 1, 1'b1);
    for (int p = 1; p <= 8; p++) begin
      pulse();
      probe("blink_slot0", 208, 5, 1'b1);
      probe("blink_slot1", 262, 5, !(p >= 3 && p <= 5));
    end
`endif

    // randomized traffic against the model
    repeat (4000) begin
      int x, y, wi, wl;
      bit sof, we, wb;
      x = $urandom_range(190, 400);
      y = $urandom_range(0, 42);
      sof = ($urandom_range(0, 19) == 0);
      we = ($urandom_range(0, 7) == 0);
      wi = $urandom_range(0, 15);
      wl = $urandom_range(0, 15);
      wb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) scrollEn = !scrollEn;
      step(x, y, sof, we, wi, wl, wb);
    end
    repeat (3) step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
